// File: rtl/seq_multiplier_16_if.sv
// Handshake and operand/result bundle between the surrounding datapath and seq_multiplier_16.
// The datapath is the master. The multiplier is the slave.
interface seq_multiplier_16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier_16.sv
// Unsigned 16x16 -> 32-bit shift-and-add multiplier, one partial-product add per clock,
// built around the two-level carry-lookahead adder adder_16.

module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] carry;
  logic [3:0]  grpG;
  logic [3:0]  grpP;
  logic [4:0]  grpC;

  // Four 4-bit groups; group carries come from a second lookahead level over grpG/grpP.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      grpP[k] = &p[4*k +: 4];
      grpG[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    grpC[0] = c_in;
    grpC[1] = grpG[0] | (grpP[0] & c_in);
    grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & c_in);
    grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
            | (grpP[2] & grpP[1] & grpP[0] & c_in);
    grpC[4] = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
            | (grpP[3] & grpP[2] & grpP[1] & grpG[0])
            | (grpP[3] & grpP[2] & grpP[1] & grpP[0] & c_in);
    for (int k = 0; k < 4; k++) begin
      carry[4*k] = grpC[k];
      for (int j = 1; j < 4; j++) begin
        carry[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & carry[4*k+j-1]);
      end
    end
    sum   = p ^ carry;
    c_out = grpC[4];
  end
endmodule

module seq_multiplier_16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier_16_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               c_q, c_d;
  logic [4:0]         count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [15:0] addSum;
  logic        addCout;
  logic [16:0] partial;

  adder_16 uAdder (
    .a     (acc_q),
    .b     (m_q),
    .c_in  (1'b0),
    .sum   (addSum),
    .c_out (addCout)
  );

  // {C,A} after the conditional add; the right shift of {C,A,Q} is folded into the slicing below.
  assign partial = q_q[0] ? {addCout, addSum} : {c_q, acc_q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    c_d       = c_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          c_d     = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = partial[16:1];
        q_d     = {partial[0], q_q[15:1]};
        c_d     = 1'b0;
        count_d = count_q + 5'd1;
        if (count_q == 5'd15) begin
          product_d = {acc_d, q_d};
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
